decode_hazard_ctrl: RTL and testbench
=====================================

# decode_hazard_ctrl

Pipeline hazard controller between the decode stage and the decode/execute pipeline latch. It tracks the destination registers of in-flight instructions in a registered scoreboard and stalls decode on read-after-write hazards, since the pipeline has no forwarding. It also squashes wrong-path instructions when execute redirects the PC, freezes the front end on data-memory stalls, and drains the pipeline after a halt. Its outputs drive the PC write enable, the fetch/decode latch, and the `nop` / `disableIDEXWrite` inputs of the decode/execute latch.

## Interface
- `WB_BYPASS`, default 1: when 1, the register file writes before it reads, so the writeback stage is not checked for hazards; when 0, it is.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `readReg1Sel_d`, `readReg2Sel_d`  in  3 each  source registers of the instruction in decode.
- `read1Used_d`, `read2Used_d`  in  1 each  the corresponding source is actually read (0 for NOP, HALT, immediate-only forms).
- `writeRegSel_d`  in  4  destination register of the decode instruction; 4'b1111 means none.
- `regWrite_d`  in  1  the decode instruction writes the register file.
- `halt_d`  in  1  the decode instruction is HALT.
- `redirect_e`  in  1  taken branch or jump resolved in execute this cycle.
- `mem_stall`  in  1  data memory is busy; the whole pipeline freezes.
- `nop`  out  1  insert a bubble into decode/execute.
- `disableIDEXWrite`  out  1  hold the decode/execute latch.
- `disableIFIDWrite`  out  1  hold the fetch/decode latch.
- `disablePCWrite`  out  1  hold the PC.
- `flush_fd`  out  1  load NOP into the fetch/decode latch.
- `halted`  out  1  HALT has entered execute.
- `stall_cycles`  out  16  saturating count of RAW stall cycles.
- `flush_count`  out  16  saturating count of accepted redirects.

## Operation
- Scoreboard registers:
  - `sb_ex`, `sb_mem`, `sb_wb` hold 4 bits each and mirror the destination fields of the EX, MEM and WB stages.
  - Value 4'b1111 means invalid. A 3-bit source register is compared as {1'b0, sel}, so an invalid entry never matches.
- RAW hazard, `raw`:
  - Set when (`read1Used_d` and `readReg1Sel_d` matches `sb_ex` or `sb_mem`), or the same condition holds for source 2.
  - `sb_wb` is included in the match only when `WB_BYPASS` = 0.
- FSM has two states, RUN and HALTING.
- Outputs in RUN, in priority order:
  1. `mem_stall`: `disablePCWrite` = `disableIFIDWrite` = `disableIDEXWrite` = 1; `nop` = 0; `flush_fd` = 0. Scoreboard, FSM and counters hold.
  2. `redirect_e`: `nop` = 1, `flush_fd` = 1, all disables 0. `flush_count` increments. A simultaneous `raw` or `halt_d` is discarded.
  3. `raw`: `nop` = 1, `disablePCWrite` = 1, `disableIFIDWrite` = 1, `disableIDEXWrite` = 0. `stall_cycles` increments.
  4. Otherwise all outputs are 0 and the instruction advances.
- Scoreboard update on each edge without `mem_stall`:
  - `sb_wb` <= `sb_mem`; `sb_mem` <= `sb_ex`.
  - `sb_ex` <= 4'b1111 when `nop` = 1 or `regWrite_d` = 0; otherwise `sb_ex` <= `writeRegSel_d`.
- RUN goes to HALTING on an edge where `halt_d` = 1 and the instruction advances, i.e. case 4 above.
- HALTING:
  - Forces `nop` = 1, `flush_fd` = 1, `disablePCWrite` = 1 and `halted` = 1.
  - `mem_stall` still freezes the pipeline as in case 1. The scoreboard keeps draining.
  - `redirect_e` is ignored: no instruction older than the HALT remains in execute.
  - HALTING is left only by reset.
- Both counters saturate at 16'hFFFF.

## Timing
- All control outputs are combinational from the scoreboard, the FSM state and the current-cycle inputs. They take effect at the next rising edge; the hazard response has zero-cycle latency.
- Stall length for a dependent instruction directly behind its producer: 2 cycles (`WB_BYPASS` = 1) or 3 cycles (`WB_BYPASS` = 0).
- Reset (`rst` = 0), applied asynchronously, including mid-stall or while HALTING:
  - All scoreboard entries become 4'b1111, the FSM goes to RUN, both counters become 0.
  - While reset is held: `nop` = 1, `flush_fd` = 1, `disablePCWrite` = 1; `disableIFIDWrite`, `disableIDEXWrite` and `halted` are 0.
- The first edge after `rst` rises operates in RUN with an empty scoreboard.

## Structure
- A shared package holds:
  - `REG_NONE` = 4'b1111;
  - the NOP encoding 16'b0000_1000_0000_0000;
  - the FSM state encodings;
  - the counter width of 16.
- One sub-module, `sat_counter`: 16-bit saturating counter with increment enable and the asynchronous active-low reset. It is instantiated twice, once per counter.

## Test plan
- Write to R3 enters execute; the next decode instruction reads R3 with `WB_BYPASS` = 1 → `nop` = 1 and `disablePCWrite` = 1 for exactly 2 cycles, release on the 3rd; `stall_cycles` = 2.
- Same sequence with `WB_BYPASS` = 0 → 3 stall cycles; a reader 3 slots behind its producer sees no stall with `WB_BYPASS` = 1.
- `redirect_e` = 1 in the same cycle as `raw` and `halt_d` → `nop` = 1, `flush_fd` = 1, disables 0, state stays RUN; `flush_count` = 1.
- `mem_stall` held for 3 cycles in the middle of a RAW stall → all three disables are 1 and the scoreboard is frozen. `stall_cycles` does not advance. After release the remaining stall cycle still occurs.
- `halt_d` advances → the next cycle shows `halted` = 1, `nop` = 1, `flush_fd` = 1, `disablePCWrite` = 1 persistently; `redirect_e` is ignored.
- Reset pulse while HALTING with `stall_cycles` = 16'hFFFF → all outputs immediately take their reset values and the counters read 0. Separately, forcing 65 540 RAW cycles leaves `stall_cycles` = 16'hFFFF.

Source files
------------

// File: rtl/decode_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// decode_hazard_ctrl_pkg
// Shared definitions for the decode-stage hazard controller:
//   - register-field encodings (REG_NONE marks an empty scoreboard slot)
//   - the NOP instruction encoding injected into the fetch/decode latch
//   - FSM state encodings and the packed control-output bundle
//   - counter width shared by the statistics counters
//   - helper that matches a decode source operand against a scoreboard entry
// -----------------------------------------------------------------------------
package decode_hazard_ctrl_pkg;

  // Width of the statistics counters (stall cycles, accepted redirects).
  localparam int unsigned CNT_W = 16;

  // Scoreboard / destination encoding meaning "no register written".
  localparam logic [3:0] REG_NONE = 4'b1111;

  // Instruction word loaded into the fetch/decode latch on a flush.
  localparam logic [15:0] NOP_INSTR = 16'b0000_1000_0000_0000;

  // Controller state: normal issue, or draining after a HALT entered execute.
  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_HALTING = 1'b1
  } hz_state_e;

  // Control outputs towards the PC, IF/ID and ID/EX latches.
  typedef struct packed {
    logic nop;
    logic dis_idex;
    logic dis_ifid;
    logic dis_pc;
    logic flush_fd;
    logic halted;
  } hz_ctrl_t;

  // A 3-bit source is widened with a zero MSB, so REG_NONE can never match.
  function automatic logic src_hits(input logic [2:0] sel,
                                    input logic       used,
                                    input logic [3:0] entry);
    return used && ({1'b0, sel} == entry);
  endfunction

endpackage : decode_hazard_ctrl_pkg

// File: rtl/decode_hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter. Increments by one on each rising edge with i_inc
// asserted and sticks at all-ones instead of wrapping.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous reset, active-low; clears the count
//   i_inc    increment enable
//   o_count  current count
// -----------------------------------------------------------------------------
module sat_counter
  import decode_hazard_ctrl_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  // Detect the saturation value so the increment can be suppressed.
  always_comb begin
    w_at_max = (r_count == {W{1'b1}});
  end

  // Count register: clears on reset, increments until it reaches all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= {W{1'b0}};
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule : sat_counter

// File: rtl/decode_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// decode_hazard_ctrl
// Hazard controller sitting between decode and the decode/execute latch of a
// pipeline without forwarding. A three-entry scoreboard mirrors the
// destination registers of the EX, MEM and WB stages; a decode source that
// matches a live entry stalls decode (read-after-write). Execute-stage
// redirects squash the wrong-path decode/fetch instructions, data-memory
// stalls freeze the front end, and a HALT that advances into execute puts the
// controller into a draining state that only reset leaves.
//
// Ports:
//   clk                    clock, rising edge
//   rst                    asynchronous reset, active-low
//   readReg1Sel_d/2Sel_d   decode source registers (3 bits each)
//   read1Used_d/2Used_d    source is really read by the decode instruction
//   writeRegSel_d          decode destination (4'b1111 = none)
//   regWrite_d             decode instruction writes the register file
//   halt_d                 decode instruction is HALT
//   redirect_e             taken branch/jump resolved in execute
//   mem_stall              data memory busy, whole pipeline frozen
//   nop                    bubble into decode/execute
//   disableIDEXWrite       hold decode/execute latch
//   disableIFIDWrite       hold fetch/decode latch
//   disablePCWrite         hold the PC
//   flush_fd               load NOP into fetch/decode latch
//   halted                 HALT has reached execute
//   stall_cycles           saturating count of RAW stall cycles
//   flush_count            saturating count of accepted redirects
//
// WB_BYPASS = 1: the register file writes before it reads, so an instruction
// in writeback can no longer cause a hazard and its slot is not compared.
// -----------------------------------------------------------------------------
module decode_hazard_ctrl
  import decode_hazard_ctrl_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       readReg1Sel_d,
  input  logic [2:0]       readReg2Sel_d,
  input  logic             read1Used_d,
  input  logic             read2Used_d,
  input  logic [3:0]       writeRegSel_d,
  input  logic             regWrite_d,
  input  logic             halt_d,
  input  logic             redirect_e,
  input  logic             mem_stall,
  output logic             nop,
  output logic             disableIDEXWrite,
  output logic             disableIFIDWrite,
  output logic             disablePCWrite,
  output logic             flush_fd,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // Scoreboard of in-flight destinations, one slot per downstream stage.
  logic [3:0] r_sb_ex;
  logic [3:0] r_sb_mem;
  logic [3:0] r_sb_wb;

  hz_state_e  r_state;
  hz_state_e  w_state_nxt;

  logic       w_wb_chk;
  logic       w_hit1;
  logic       w_hit2;
  logic       w_raw;
  hz_ctrl_t   w_ctrl;
  logic       w_stall_inc;
  logic       w_flush_inc;

  // Read-after-write detection against the live scoreboard slots.
  always_comb begin
    w_wb_chk = (WB_BYPASS == 1'b0);
    w_hit1   = src_hits(readReg1Sel_d, read1Used_d, r_sb_ex)
             | src_hits(readReg1Sel_d, read1Used_d, r_sb_mem)
             | (w_wb_chk & src_hits(readReg1Sel_d, read1Used_d, r_sb_wb));
    w_hit2   = src_hits(readReg2Sel_d, read2Used_d, r_sb_ex)
             | src_hits(readReg2Sel_d, read2Used_d, r_sb_mem)
             | (w_wb_chk & src_hits(readReg2Sel_d, read2Used_d, r_sb_wb));
    w_raw    = w_hit1 | w_hit2;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a HALT moves to HALTING only when it actually advances,
  // i.e. no freeze, no squash and no RAW stall this cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (!mem_stall && !redirect_e && !w_raw && halt_d) begin
          w_state_nxt = ST_HALTING;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALTING: begin
        w_state_nxt = ST_HALTING;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // FSM outputs and counter strobes, prioritised freeze > redirect > RAW.
  always_comb begin
    w_ctrl      = '0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (!rst) begin
      // Hold the PC and feed bubbles while reset is asserted.
      w_ctrl.nop    = 1'b1;
      w_ctrl.flush_fd = 1'b1;
      w_ctrl.dis_pc = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (mem_stall) begin
            w_ctrl.dis_pc   = 1'b1;
            w_ctrl.dis_ifid = 1'b1;
            w_ctrl.dis_idex = 1'b1;
          end else if (redirect_e) begin
            // Wrong-path instructions in fetch and decode are discarded,
            // together with any hazard or HALT they carried.
            w_ctrl.nop      = 1'b1;
            w_ctrl.flush_fd = 1'b1;
            w_flush_inc     = 1'b1;
          end else if (w_raw) begin
            w_ctrl.nop      = 1'b1;
            w_ctrl.dis_pc   = 1'b1;
            w_ctrl.dis_ifid = 1'b1;
            w_stall_inc     = 1'b1;
          end else begin
            w_ctrl = '0;
          end
        end
        ST_HALTING: begin
          // Nothing younger than the HALT may issue; execute still drains.
          w_ctrl.nop      = 1'b1;
          w_ctrl.flush_fd = 1'b1;
          w_ctrl.dis_pc   = 1'b1;
          w_ctrl.halted   = 1'b1;
          if (mem_stall) begin
            w_ctrl.dis_ifid = 1'b1;
            w_ctrl.dis_idex = 1'b1;
          end else begin
            w_ctrl.dis_ifid = 1'b0;
            w_ctrl.dis_idex = 1'b0;
          end
        end
        default: begin
          w_ctrl.nop      = 1'b1;
          w_ctrl.flush_fd = 1'b1;
          w_ctrl.dis_pc   = 1'b1;
        end
      endcase
    end
  end

  // Scoreboard shift: frozen by mem_stall, bubbles enter EX as REG_NONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sb_ex  <= REG_NONE;
      r_sb_mem <= REG_NONE;
      r_sb_wb  <= REG_NONE;
    end else if (mem_stall) begin
      r_sb_ex  <= r_sb_ex;
      r_sb_mem <= r_sb_mem;
      r_sb_wb  <= r_sb_wb;
    end else begin
      r_sb_wb  <= r_sb_mem;
      r_sb_mem <= r_sb_ex;
      if (w_ctrl.nop || !regWrite_d) begin
        r_sb_ex <= REG_NONE;
      end else begin
        r_sb_ex <= writeRegSel_d;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (w_stall_inc),
    .o_count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (w_flush_inc),
    .o_count (flush_count)
  );

  assign nop              = w_ctrl.nop;
  assign disableIDEXWrite = w_ctrl.dis_idex;
  assign disableIFIDWrite = w_ctrl.dis_ifid;
  assign disablePCWrite   = w_ctrl.dis_pc;
  assign flush_fd         = w_ctrl.flush_fd;
  assign halted           = w_ctrl.halted;

endmodule : decode_hazard_ctrl

// File: tb/tb_decode_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_decode_hazard_ctrl
// Two controllers (WB_BYPASS = 1 and 0) share one stimulus stream. A table of
// per-cycle vectors holds inputs and hand-derived outputs for both, plus the
// counter values expected before that cycle's edge. Hand-written sequences
// cover reset while HALTING and counter saturation.
// Output bundle bit order: {nop, disableIDEXWrite, disableIFIDWrite,
// disablePCWrite, flush_fd, halted}.
// -----------------------------------------------------------------------------
module tb_decode_hazard_ctrl;

  localparam logic [5:0] O_Z = 6'b000000; // advance
  localparam logic [5:0] O_S = 6'b101100; // RAW stall
  localparam logic [5:0] O_M = 6'b011100; // memory freeze
  localparam logic [5:0] O_R = 6'b100010; // redirect squash
  localparam logic [5:0] O_H = 6'b100111; // halting
  localparam logic [5:0] O_X = 6'b100110; // reset held

  typedef struct {
    logic [2:0] r1;
    logic       r1u;
    logic [2:0] r2;
    logic       r2u;
    logic [3:0] w;
    logic       rw;
    logic       h;
    logic       rd;
    logic       ms;
    logic [5:0] e1;
    logic [5:0] e0;
    int         sc1;
    int         sc0;
    int         fc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  r1sel = 3'd0;
  logic [2:0]  r2sel = 3'd0;
  logic        r1u = 1'b0;
  logic        r2u = 1'b0;
  logic [3:0]  wsel = 4'hF;
  logic        rw = 1'b0;
  logic        hlt = 1'b0;
  logic        redir = 1'b0;
  logic        mstall = 1'b0;
  logic        cnt_inc = 1'b0;

  logic        nop1, idex1, ifid1, pc1, fl1, hd1;
  logic        nop0, idex0, ifid0, pc0, fl0, hd0;
  logic [15:0] sc1, fc1, sc0, fc0, ucnt;
  logic [5:0]  out1, out0;

  int checks = 0;
  int errors = 0;
  vec_t vecs[30];

  assign out1 = {nop1, idex1, ifid1, pc1, fl1, hd1};
  assign out0 = {nop0, idex0, ifid0, pc0, fl0, hd0};

  always #5 clk = ~clk;

  decode_hazard_ctrl #(.WB_BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .readReg1Sel_d(r1sel), .readReg2Sel_d(r2sel),
    .read1Used_d(r1u), .read2Used_d(r2u),
    .writeRegSel_d(wsel), .regWrite_d(rw), .halt_d(hlt),
    .redirect_e(redir), .mem_stall(mstall),
    .nop(nop1), .disableIDEXWrite(idex1), .disableIFIDWrite(ifid1),
    .disablePCWrite(pc1), .flush_fd(fl1), .halted(hd1),
    .stall_cycles(sc1), .flush_count(fc1)
  );

  decode_hazard_ctrl #(.WB_BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .readReg1Sel_d(r1sel), .readReg2Sel_d(r2sel),
    .read1Used_d(r1u), .read2Used_d(r2u),
    .writeRegSel_d(wsel), .regWrite_d(rw), .halt_d(hlt),
    .redirect_e(redir), .mem_stall(mstall),
    .nop(nop0), .disableIDEXWrite(idex0), .disableIFIDWrite(ifid0),
    .disablePCWrite(pc0), .flush_fd(fl0), .halted(hd0),
    .stall_cycles(sc0), .flush_count(fc0)
  );

  sat_counter #(.W(16)) u_cnt (
    .i_clk(clk), .i_rst_n(rst), .i_inc(cnt_inc), .o_count(ucnt)
  );

  function automatic vec_t mk(input logic [2:0] a_r1, input logic a_r1u,
                              input logic [2:0] a_r2, input logic a_r2u,
                              input logic [3:0] a_w, input logic a_rw,
                              input logic a_h, input logic a_rd, input logic a_ms,
                              input logic [5:0] a_e1, input logic [5:0] a_e0,
                              input int a_sc1, input int a_sc0, input int a_fc);
    vec_t v;
    v.r1 = a_r1; v.r1u = a_r1u; v.r2 = a_r2; v.r2u = a_r2u;
    v.w = a_w; v.rw = a_rw; v.h = a_h; v.rd = a_rd; v.ms = a_ms;
    v.e1 = a_e1; v.e0 = a_e0; v.sc1 = a_sc1; v.sc0 = a_sc0; v.fc = a_fc;
    return v;
  endfunction

  task automatic chk6(input string name, input int idx,
                      input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %b want %b", name, idx, act, exp);
    end
  endtask

  task automatic chk16(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] a_r1, input logic a_r1u,
                       input logic [2:0] a_r2, input logic a_r2u,
                       input logic [3:0] a_w, input logic a_rw,
                       input logic a_h, input logic a_rd, input logic a_ms);
    r1sel = a_r1; r1u = a_r1u; r2sel = a_r2; r2u = a_r2u;
    wsel = a_w; rw = a_rw; hlt = a_h; redir = a_rd; mstall = a_ms;
  endtask

  initial begin
    // RAW on R3 directly behind its producer: 2 stalls (bypass) / 3 stalls.
    vecs[0]  = mk(3'd0,1'b0,3'd0,1'b0,4'd3, 1'b1,1'b0,1'b0,1'b0,O_Z,O_Z,0,0,0);
    vecs[1]  = mk(3'd3,1'b1,3'd0,1'b0,4'd4, 1'b1,1'b0,1'b0,1'b0,O_S,O_S,0,0,0);
    vecs[2]  = mk(3'd3,1'b1,3'd0,1'b0,4'd4, 1'b1,1'b0,1'b0,1'b0,O_S,O_S,1,1,0);
    vecs[3]  = mk(3'd3,1'b1,3'd0,1'b0,4'd4, 1'b1,1'b0,1'b0,1'b0,O_Z,O_S,2,2,0);
    vecs[4]  = mk(3'd3,1'b1,3'd0,1'b0,4'd4, 1'b1,1'b0,1'b0,1'b0,O_Z,O_Z,2,3,0);
    vecs[5]  = mk(3'd0,1'b0,3'd0,1'b0,4'hF, 1'b0,1'b0,1'b0,1'b0,O_Z,O_Z,2,3,0);
    vecs[6]  = mk(3'd0,1'b0,3'd0,1'b0,4'hF, 1'b0,1'b0,1'b0,1'b0,O_Z,O_Z,2,3,0);
    vecs[7]  = mk(3'd0,1'b0,3'd0,1'b0,4'hF, 1'b0,1'b0,1'b0,1'b0,O_Z,O_Z,2,3,0);
    // Reader of R5 three slots behind: only the non-bypass copy stalls.
    vecs[8]  = mk(3'd0,1'b0,3'd0,1'b0,4'd5, 1'b1,1'b0,1'b0,1'b0,O_Z,O_Z,2,3,0);
    vecs[9]  = mk(3'd0,1'b0,3'd0,1'b0,4'hF, 1'b0,1'b0,1'b0,1'b0,O_Z,O_Z,2,3,0);
    vecs[10] = mk(3'd0,1'b0,3'd0,1'b0,4'hF, 1'b0,1'b0,1'b0,1'b0,O_Z,O_Z,2,3,0);
    vecs[11] = mk(3'd0,1'b0,3'd5,1'b1,4'hF, 1'b0,1'b0,1'b0,1'b0,O_Z,O_S,2,3,0);
    // Unused sources never stall.
    vecs[12] = mk(3'd0,1'b0,3'd0,1'b0,4'd6, 1'b1,1'b0,1'b0,1'b0,O_Z,O_Z,2,4,0);
    vecs[13] = mk(3'd6,1'b0,3'd6,1'b0,4'hF, 1'b0,1'b0,1'b0,1'b0,O_Z,O_Z,2,4,0);
    vecs[14] = mk(3'd0,1'b0,3'd0,1'b0,4'hF, 1'b0,1'b0,1'b0,1'b0,O_Z,O_Z,2,4,0);
    vecs[15] = mk(3'd0,1'b0,3'd0,1'b0,4'hF, 1'b0,1'b0,1'b0,1'b0,O_Z,O_Z,2,4,0);
    // RAW on R7 via source 2, frozen 3 cycles by mem_stall mid-stall.
    vecs[16] = mk(3'd0,1'b0,3'd0,1'b0,4'd7, 1'b1,1'b0,1'b0,1'b0,O_Z,O_Z,2,4,0);
    vecs[17] = mk(3'd0,1'b1,3'd7,1'b1,4'hF, 1'b0,1'b0,1'b0,1'b0,O_S,O_S,2,4,0);
    vecs[18] = mk(3'd0,1'b1,3'd7,1'b1,4'hF, 1'b0,1'b0,1'b0,1'b1,O_M,O_M,3,5,0);
    vecs[19] = mk(3'd0,1'b1,3'd7,1'b1,4'hF, 1'b0,1'b0,1'b0,1'b1,O_M,O_M,3,5,0);
    vecs[20] = mk(3'd0,1'b1,3'd7,1'b1,4'hF, 1'b0,1'b0,1'b0,1'b1,O_M,O_M,3,5,0);
    vecs[21] = mk(3'd0,1'b1,3'd7,1'b1,4'hF, 1'b0,1'b0,1'b0,1'b0,O_S,O_S,3,5,0);
    vecs[22] = mk(3'd0,1'b1,3'd7,1'b1,4'hF, 1'b0,1'b0,1'b0,1'b0,O_Z,O_S,4,6,0);
    // Redirect together with RAW and HALT: squash wins, stays in RUN.
    vecs[23] = mk(3'd0,1'b0,3'd0,1'b0,4'd2, 1'b1,1'b0,1'b0,1'b0,O_Z,O_Z,4,7,0);
    vecs[24] = mk(3'd2,1'b1,3'd0,1'b0,4'hF, 1'b0,1'b1,1'b1,1'b0,O_R,O_R,4,7,0);
    vecs[25] = mk(3'd0,1'b0,3'd0,1'b0,4'hF, 1'b0,1'b0,1'b0,1'b0,O_Z,O_Z,4,7,1);
    vecs[26] = mk(3'd0,1'b0,3'd0,1'b0,4'hF, 1'b0,1'b0,1'b0,1'b0,O_Z,O_Z,4,7,1);
    // HALT advances; HALTING ignores redirect.
    vecs[27] = mk(3'd0,1'b0,3'd0,1'b0,4'hF, 1'b0,1'b1,1'b0,1'b0,O_Z,O_Z,4,7,1);
    vecs[28] = mk(3'd0,1'b0,3'd0,1'b0,4'hF, 1'b0,1'b0,1'b1,1'b0,O_H,O_H,4,7,1);
    vecs[29] = mk(3'd0,1'b0,3'd0,1'b0,4'hF, 1'b0,1'b1,1'b1,1'b0,O_H,O_H,4,7,1);

    // Reset asserted from the start: outputs and counters at reset values.
    #1 rst = 1'b0;
    #2;
    chk6("reset_out_bypass", 0, out1, O_X);
    chk6("reset_out_nobypass", 0, out0, O_X);
    chk16("reset_stall_cnt", 0, sc1, 16'h0000);
    chk16("reset_flush_cnt", 0, fc0, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive(vecs[i].r1, vecs[i].r1u, vecs[i].r2, vecs[i].r2u, vecs[i].w,
            vecs[i].rw, vecs[i].h, vecs[i].rd, vecs[i].ms);
      #1;
      chk6("ctrl_bypass", i, out1, vecs[i].e1);
      chk6("ctrl_nobypass", i, out0, vecs[i].e0);
      chk16("stall_cnt_bypass", i, sc1, 16'(vecs[i].sc1));
      chk16("stall_cnt_nobypass", i, sc0, 16'(vecs[i].sc0));
      chk16("flush_cnt", i, fc1, 16'(vecs[i].fc));
    end

    // Asynchronous reset in the middle of a cycle while HALTING.
    @(negedge clk);
    drive(3'd0, 1'b0, 3'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk6("halt_reset_out_bypass", 100, out1, O_X);
    chk6("halt_reset_out_nobypass", 100, out0, O_X);
    chk16("halt_reset_stall_cnt", 100, sc0, 16'h0000);
    chk16("halt_reset_flush_cnt", 100, fc1, 16'h0000);

    // First cycle after release runs in RUN with an empty scoreboard.
    @(negedge clk);
    rst = 1'b1;
    drive(3'd3, 1'b1, 3'd7, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk6("post_reset_bypass", 101, out1, O_Z);
    chk6("post_reset_nobypass", 101, out0, O_Z);

    // Self-dependent instruction held in decode for 65540 cycles:
    // bypass stalls 2 of every 3 cycles, non-bypass 3 of every 4.
    // The standalone counter increments every cycle and must stick at FFFF.
    @(negedge clk);
    drive(3'd1, 1'b1, 3'd0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    cnt_inc = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    chk16("long_stall_cnt_bypass", 102, sc1, 16'd43693);
    chk16("long_stall_cnt_nobypass", 102, sc0, 16'd49155);
    chk16("sat_counter_saturates", 102, ucnt, 16'hFFFF);
    @(posedge clk);
    #1;
    chk16("sat_counter_holds", 103, ucnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_decode_hazard_ctrl
